// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch queue.
// Optional stall counter is enabled by defining FETCH_STALL_CNT_EN.
package fetch_pkg;
  localparam int WORD_W = 16;
  localparam int DEF_DEPTH = 4;
  localparam logic [WORD_W-1:0] DEF_RESET_PC = 16'h0000;

  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Instruction queue storage: power-of-two ring buffer with flush.
// Pointers wrap naturally; count tracks occupancy 0..DEPTH.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  fetch_entry_t           pushData,
  input  logic                   pop,
  input  logic                   flush,
  output fetch_entry_t           head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  fetch_entry_t mem [DEPTH];
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;
  logic doPush;
  logic doPop;

  assign doPush = push && !full && !flush;
  assign doPop  = pop && !empty && !flush;
  assign full   = count == FULL_CNT;
  assign empty  = count == '0;
  assign head   = mem[rdPtr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else if (flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + AW'(1);
      if (doPop)  rdPtr <= rdPtr + AW'(1);
      count <= count + {{AW{1'b0}}, doPush}
                     - {{AW{1'b0}}, doPop};
    end
  end

  // Storage needs no reset; validity lives in count.
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= pushData;
  end
endmodule

// File: rtl/fetch_queue.sv
// Fetch front end: PC, one-deep credit for the 1-cycle memory, queue.
// Define FETCH_STALL_CNT_EN to add the stallCycles counter output.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int                DEPTH    = DEF_DEPTH,
  parameter logic [WORD_W-1:0] RESET_PC = DEF_RESET_PC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              redirectValid,
  input  logic [WORD_W-1:0] redirectPc,
  output logic              fetchEnable,
  output logic [WORD_W-1:0] fetchAddr,
  input  logic              fetchReady,
  input  logic [WORD_W-1:0] fetchData,
  input  logic [WORD_W-1:0] fetchOutpc,
  output logic              decValid,
  input  logic              decReady,
  output logic [WORD_W-1:0] decInstr,
  output logic [WORD_W-1:0] decPc
`ifdef FETCH_STALL_CNT_EN
  ,
  output logic [WORD_W-1:0] stallCycles
`endif
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] MAX_CRED = (CW+1)'(DEPTH);

  logic [WORD_W-1:0] pc;
  logic              inflight;
  logic [CW-1:0]     count;
  logic [CW:0]       credits;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  fetch_entry_t      head;
  fetch_entry_t      pushData;

  // Queued entries plus the outstanding request must fit in the queue.
  assign credits     = {1'b0, count} + {{CW{1'b0}}, inflight};
  assign fetchEnable = !reset && !redirectValid && (credits < MAX_CRED);
  assign fetchAddr   = fetchEnable ? pc : '0;

  assign push     = fetchReady && !redirectValid;
  assign pushData = '{pc: fetchOutpc, instr: fetchData};
  assign decValid = !empty && !redirectValid;
  assign pop      = decValid && decReady;
  assign decInstr = decValid ? head.instr : '0;
  assign decPc    = decValid ? head.pc : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc       <= RESET_PC;
      inflight <= 1'b0;
    end else if (redirectValid) begin
      pc       <= redirectPc;
      inflight <= 1'b0;
    end else begin
      inflight <= fetchEnable;
      if (fetchEnable) pc <= pc + 16'd1;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) uFifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .pushData (pushData),
    .pop      (pop),
    .flush    (redirectValid),
    .head     (head),
    .full     (full),
    .empty    (empty),
    .count    (count)
  );

  pushIntoFull: assert property (
    @(posedge clk) disable iff (reset) !(push && full)
  );

`ifdef FETCH_STALL_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stallCycles <= '0;
    end else if (decReady && !decValid && stallCycles != 16'hFFFF) begin
      stallCycles <= stallCycles + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue with a 1-cycle memory model.
// Covers FETCH_STALL_CNT_EN checks when that macro is defined.
module tb_fetch_queue;
  import fetch_pkg::*;

  localparam logic [15:0] RST_PC = 16'h0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirectValid;
  logic [15:0] redirectPc;
  logic        fetchEnable;
  logic [15:0] fetchAddr;
  logic        fetchReady;
  logic [15:0] fetchData;
  logic [15:0] fetchOutpc;
  logic        decValid;
  logic        decReady;
  logic [15:0] decInstr;
  logic [15:0] decPc;
`ifdef FETCH_STALL_CNT_EN
  logic [15:0] stallCycles;
  logic [15:0] sc0;
`endif

  int tests = 0;
  int fails = 0;
  fetch_entry_t expQ[$];

  logic        memRdy = 1'b0;
  logic [15:0] memPc = 16'h0000;

  fetch_queue #(.DEPTH(4), .RESET_PC(RST_PC)) dut (
    .clk           (clk),
    .reset         (reset),
    .redirectValid (redirectValid),
    .redirectPc    (redirectPc),
    .fetchEnable   (fetchEnable),
    .fetchAddr     (fetchAddr),
    .fetchReady    (fetchReady),
    .fetchData     (fetchData),
    .fetchOutpc    (fetchOutpc),
    .decValid      (decValid),
    .decReady      (decReady),
    .decInstr      (decInstr),
    .decPc         (decPc)
`ifdef FETCH_STALL_CNT_EN
    ,
    .stallCycles   (stallCycles)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] memWord(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h3C5A;
  endfunction

  always @(posedge clk) begin
    memRdy <= fetchEnable;
    memPc  <= fetchAddr;
  end
  assign fetchReady = memRdy;
  assign fetchData  = memRdy ? memWord(memPc) : 16'h0000;
  assign fetchOutpc = memRdy ? memPc : 16'h0000;

  task automatic chk(input string tag, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    fetch_entry_t e;
    logic expV;
    if (reset) begin
      expQ.delete();
    end else begin
      expV = (expQ.size() != 0) && !redirectValid;
      chk("decValid", 32'(decValid), 32'(expV));
      if (expV && decReady) begin
        e = expQ.pop_front();
        chk("decPc", 32'(decPc), 32'(e.pc));
        chk("decInstr", 32'(decInstr), 32'(e.instr));
      end else if (!expV) begin
        chk("idlePc", 32'(decPc), 32'h0);
        chk("idleInstr", 32'(decInstr), 32'h0);
      end
      if (redirectValid) expQ.delete();
      else if (fetchReady) expQ.push_back('{pc: fetchOutpc, instr: fetchData});
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: no finish by %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int issued;
    logic found;
    reset = 1'b1;
    redirectValid = 1'b0;
    redirectPc = 16'h0000;
    decReady = 1'b1;
    repeat (2) tick();
    chk("rstFe", 32'(fetchEnable), 32'h0);
    chk("rstAddr", 32'(fetchAddr), 32'h0);
    chk("rstDv", 32'(decValid), 32'h0);
    chk("rstPc", 32'(decPc), 32'h0);
    chk("rstInstr", 32'(decInstr), 32'h0);
`ifdef FETCH_STALL_CNT_EN
    chk("rstStall", 32'(stallCycles), 32'h0);
`endif

    // streaming after reset
    reset = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) begin
      chk("seqFe", 32'(fetchEnable), 32'h1);
      chk("seqAddr", 32'(fetchAddr), 32'(16'(RST_PC + i)));
      if (i >= 2) begin
        chk("seqDv", 32'(decValid), 32'h1);
        chk("seqPc", 32'(decPc), 32'(16'(RST_PC + i - 2)));
        chk("seqInstr", 32'(decInstr), 32'(memWord(16'(RST_PC + i - 2))));
      end
      tick();
    end

    // backpressure: exactly DEPTH fetches then stop
    decReady = 1'b0;
    redirectValid = 1'b1;
    redirectPc = 16'h0100;
    tick();
    redirectValid = 1'b0;
    #1;
    issued = 0;
    repeat (10) begin
      if (fetchEnable) begin
        chk("bpAddr", 32'(fetchAddr), 32'(16'(16'h0100 + issued)));
        issued++;
      end
      tick();
    end
    chk("bpIssued", 32'(issued), 32'd4);
    chk("bpFe", 32'(fetchEnable), 32'h0);
    chk("bpDv", 32'(decValid), 32'h1);
    chk("bpOcc", 32'(expQ.size()), 32'd4);
    decReady = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("bpPc", 32'(decPc), 32'(16'(16'h0100 + k)));
      tick();
    end

    // redirect with 3 queued and a response in flight
    decReady = 1'b0;
    redirectValid = 1'b1;
    redirectPc = 16'h0300;
    tick();
    redirectValid = 1'b0;
    found = 1'b0;
    for (int w = 0; w < 20 && !found; w++) begin
      #1;
      if (expQ.size() == 3 && fetchReady) found = 1'b1;
      else tick();
    end
    chk("rdSetup", 32'(found), 32'h1);
    decReady = 1'b1;
    redirectValid = 1'b1;
    redirectPc = 16'h0200;
`ifdef FETCH_STALL_CNT_EN
    sc0 = stallCycles;
`endif
    #1;
    chk("rdFe0", 32'(fetchEnable), 32'h0);
    chk("rdDv0", 32'(decValid), 32'h0);
    tick();
    redirectValid = 1'b0;
    #1;
    chk("rdFe1", 32'(fetchEnable), 32'h1);
    chk("rdAddr", 32'(fetchAddr), 32'h0200);
    chk("rdDv1", 32'(decValid), 32'h0);
    tick();
    chk("rdRdy", 32'(fetchReady), 32'h1);
    chk("rdDv2", 32'(decValid), 32'h0);
    tick();
    chk("rdDv3", 32'(decValid), 32'h1);
    chk("rdPc3", 32'(decPc), 32'h0200);
    chk("rdInstr3", 32'(decInstr), 32'(memWord(16'h0200)));
`ifdef FETCH_STALL_CNT_EN
    chk("stallDelta", 32'(16'(stallCycles - sc0)), 32'd3);
`endif

    // pc wrap
    redirectValid = 1'b1;
    redirectPc = 16'hFFFE;
    tick();
    redirectValid = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("wrapAddr", 32'(fetchAddr), 32'(16'(16'hFFFE + k)));
      tick();
    end
    repeat (3) tick();

    // asynchronous reset mid-stream
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("amFe", 32'(fetchEnable), 32'h0);
    chk("amAddr", 32'(fetchAddr), 32'h0);
    chk("amDv", 32'(decValid), 32'h0);
    chk("amPc", 32'(decPc), 32'h0);
    chk("amInstr", 32'(decInstr), 32'h0);
`ifdef FETCH_STALL_CNT_EN
    chk("amStall", 32'(stallCycles), 32'h0);
`endif
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("amFirstFe", 32'(fetchEnable), 32'h1);
    chk("amFirstAddr", 32'(fetchAddr), 32'(RST_PC));
    tick();
    tick();
    chk("amFirstPc", 32'(decPc), 32'(RST_PC));
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
